// File: rtl/regex_cpu_pipelined.sv
// Pipelined regex VM core: one thread PC per slot flows through
// fetch -> memory wait -> execute, and successor PCs leave through a small FIFO.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   current_character          character the executing thread is matched against
//   input_pc_valid/_ready/pc   thread PC from the scheduler (ready = fetch slot empty)
//   memory_valid/_ready/addr   instruction fetch request to the memory arbiter
//   memory_data                instruction word, valid one cycle after acceptance
//   output_pc_valid/_ready/pc  successor PC to the scheduler (FIFO head)
//   output_pc_is_directed_to_current  1 = run on current char, 0 = on next char
//   accepts                    one-cycle pulse when an accepting instruction executes
//   running                    any stage or the FIFO holds work
module regex_cpu_pipelined #(
  parameter int PC_WIDTH              = 8,
  parameter int CHARACTER_WIDTH       = 8,
  parameter int MEMORY_WIDTH          = 16,
  parameter int MEMORY_ADDR_WIDTH     = 11,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHARACTER_WIDTH-1:0]   current_character,
  input  logic                         input_pc_valid,
  input  logic [PC_WIDTH-1:0]          input_pc,
  output logic                         input_pc_ready,
  input  logic                         memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
  input  logic [MEMORY_WIDTH-1:0]      memory_data,
  output logic                         memory_valid,
  output logic                         output_pc_is_directed_to_current,
  output logic                         output_pc_valid,
  output logic [PC_WIDTH-1:0]          output_pc,
  input  logic                         output_pc_ready,
  output logic                         accepts,
  output logic                         running
);

  localparam int FIFO_DEPTH = 1 << FIFO_WIDTH_POWER_OF_2;
  localparam int PTR_W      = FIFO_WIDTH_POWER_OF_2 + 1;

  typedef enum logic [2:0] {
    OP_ACCEPT         = 3'd0,
    OP_SPLIT          = 3'd1,
    OP_MATCH          = 3'd2,
    OP_JMP            = 3'd3,
    OP_END            = 3'd4,
    OP_MATCH_ANY      = 3'd5,
    OP_ACCEPT_PARTIAL = 3'd6,
    OP_NOT_MATCH      = 3'd7
  } opcode_e;

  logic                       f_valid_r;
  logic [PC_WIDTH-1:0]        f_pc_r;
  logic                       m_valid_r;
  logic [PC_WIDTH-1:0]        m_pc_r;
  logic                       e_valid_r;
  logic [PC_WIDTH-1:0]        e_pc_r;
  logic [MEMORY_WIDTH-1:0]    e_instr_r;
  logic                       e_second_r;
  logic [PC_WIDTH:0]          fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic                       accepts_r;

  opcode_e                    opcode_s;
  logic [CHARACTER_WIDTH-1:0] operand_s;
  logic [PC_WIDTH-1:0]        target_s;
  logic                       instr_unused_s;
  logic                       empty_s;
  logic                       full_s;
  logic                       pop_s;
  logic                       can_push_s;
  logic                       push_s;
  logic                       push_dir_s;
  logic [PC_WIDTH-1:0]        push_pc_s;
  logic                       e_done_s;
  logic                       accept_hit_s;
  logic                       f_issue_s;

  assign opcode_s       = opcode_e'(e_instr_r[MEMORY_WIDTH-1 -: 3]);
  assign operand_s      = e_instr_r[CHARACTER_WIDTH-1:0];
  assign target_s       = e_instr_r[PC_WIDTH-1:0];
  assign instr_unused_s = ^e_instr_r;

  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign full_s     = ((wr_ptr_r - rd_ptr_r) == PTR_W'(FIFO_DEPTH));
  assign pop_s      = !empty_s && output_pc_ready;
  // A full FIFO still takes a push in the cycle its head is popped.
  assign can_push_s = !full_s || pop_s;

  // The fetch only goes out when M is free and E will be free by the time
  // the word arrives, so M never has to stall.
  assign f_issue_s = f_valid_r && !m_valid_r && (!e_valid_r || e_done_s);

  assign input_pc_ready = !f_valid_r;
  assign memory_valid   = f_issue_s;
  assign memory_addr    = MEMORY_ADDR_WIDTH'(f_pc_r);

  assign output_pc_valid = !empty_s;
  assign {output_pc_is_directed_to_current, output_pc} =
    fifo_mem_r[rd_ptr_r[FIFO_WIDTH_POWER_OF_2-1:0]];
  assign accepts = accepts_r;
  assign running = f_valid_r || m_valid_r || e_valid_r || !empty_s;

  // Execute-stage decode: what to push, and whether the thread leaves E.
  always_comb begin
    push_s       = 1'b0;
    push_dir_s   = 1'b0;
    push_pc_s    = e_pc_r + PC_WIDTH'(1);
    e_done_s     = 1'b0;
    accept_hit_s = 1'b0;
    if (e_valid_r) begin
      case (opcode_s)
        OP_MATCH: begin
          if (operand_s == current_character) begin
            push_s   = can_push_s;
            e_done_s = can_push_s;
          end else begin
            e_done_s = 1'b1;
          end
        end
        OP_NOT_MATCH: begin
          if (operand_s != current_character) begin
            push_s   = can_push_s;
            e_done_s = can_push_s;
          end else begin
            e_done_s = 1'b1;
          end
        end
        OP_MATCH_ANY: begin
          push_s   = can_push_s;
          e_done_s = can_push_s;
        end
        OP_JMP: begin
          push_s     = can_push_s;
          push_dir_s = 1'b1;
          push_pc_s  = target_s;
          e_done_s   = can_push_s;
        end
        // First push is pc+1, second push (E held) is the target.
        OP_SPLIT: begin
          push_s     = can_push_s;
          push_dir_s = 1'b1;
          if (e_second_r) begin
            push_pc_s = target_s;
          end else begin
            push_pc_s = e_pc_r + PC_WIDTH'(1);
          end
          e_done_s = can_push_s && e_second_r;
        end
        OP_ACCEPT: begin
          e_done_s     = 1'b1;
          accept_hit_s = (current_character == CHARACTER_WIDTH'(0));
        end
        OP_ACCEPT_PARTIAL: begin
          e_done_s     = 1'b1;
          accept_hit_s = 1'b1;
        end
        OP_END: begin
          e_done_s = 1'b1;
        end
        default: begin
          e_done_s = 1'b1;
        end
      endcase
    end else begin
      e_done_s = 1'b0;
    end
  end

  // Fetch stage: load a PC when empty, release it once memory takes the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_valid_r <= 1'b0;
      f_pc_r    <= '0;
    end else if (input_pc_valid && input_pc_ready) begin
      f_valid_r <= 1'b1;
      f_pc_r    <= input_pc;
    end else if (f_issue_s && memory_ready) begin
      f_valid_r <= 1'b0;
    end
  end

  // Memory-wait stage: holds the PC for the cycle the instruction word is read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_pc_r    <= '0;
    end else begin
      m_valid_r <= f_issue_s && memory_ready;
      if (f_issue_s && memory_ready) begin
        m_pc_r <= f_pc_r;
      end
    end
  end

  // Execute stage register: capture PC plus instruction word, retire when done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_r  <= 1'b0;
      e_pc_r     <= '0;
      e_instr_r  <= '0;
      e_second_r <= 1'b0;
    end else if (m_valid_r) begin
      e_valid_r  <= 1'b1;
      e_pc_r     <= m_pc_r;
      e_instr_r  <= memory_data;
      e_second_r <= 1'b0;
    end else if (e_done_s) begin
      e_valid_r  <= 1'b0;
      e_second_r <= 1'b0;
    end else if (push_s) begin
      e_second_r <= 1'b1;
    end
  end

  // Output FIFO storage and pointers; extra pointer bit separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[FIFO_WIDTH_POWER_OF_2-1:0]] <= {push_dir_s, push_pc_s};
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Registered accept pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accepts_r <= 1'b0;
    end else begin
      accepts_r <= accept_hit_s;
    end
  end

endmodule

// File: tb/tb_regex_cpu_pipelined.sv
module tb_regex_cpu_pipelined;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  current_character = 8'h00;
  logic        input_pc_valid = 1'b0;
  logic [7:0]  input_pc = 8'h00;
  logic        input_pc_ready;
  logic        memory_ready = 1'b0;
  logic [10:0] memory_addr;
  logic [15:0] memory_data = 16'h0000;
  logic        memory_valid;
  logic        output_pc_is_directed_to_current;
  logic        output_pc_valid;
  logic [7:0]  output_pc;
  logic        output_pc_ready = 1'b1;
  logic        accepts;
  logic        running;

  int checks = 0;
  int passed = 0;
  int acc_cnt = 0;
  logic [8:0] exp_q[$];

  localparam logic [2:0] ACCEPT = 3'd0, SPLIT = 3'd1, MATCH = 3'd2, JMP = 3'd3,
                         ENDW = 3'd4, MATCH_ANY = 3'd5, ACCEPT_PARTIAL = 3'd6,
                         NOT_MATCH = 3'd7;

  regex_cpu_pipelined dut (
    .clk(clk), .reset(reset), .current_character(current_character),
    .input_pc_valid(input_pc_valid), .input_pc(input_pc), .input_pc_ready(input_pc_ready),
    .memory_ready(memory_ready), .memory_addr(memory_addr), .memory_data(memory_data),
    .memory_valid(memory_valid),
    .output_pc_is_directed_to_current(output_pc_is_directed_to_current),
    .output_pc_valid(output_pc_valid), .output_pc(output_pc),
    .output_pc_ready(output_pc_ready), .accepts(accepts), .running(running)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard whenever the DUT hands over an output PC.
  always @(negedge clk) begin
    if (!reset) begin
      if (accepts) acc_cnt++;
      if (output_pc_valid && output_pc_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got dir=%0b pc=%h, none expected",
                   output_pc_is_directed_to_current, output_pc);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({output_pc_is_directed_to_current, output_pc} === e) passed++;
          else $display("FAIL out_pc: got dir=%0b pc=%h, expected dir=%0b pc=%h",
                        output_pc_is_directed_to_current, output_pc, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (running && t < 200) begin
      step(1);
      t++;
    end
    check(name, {31'd0, running}, 32'd0);
  endtask

  // Issue one thread: offer PC for 'hold' cycles, serve one fetch with 'instr'.
  // Returns just after the word has been captured into E.
  task automatic run_thread(input logic [7:0] pc, input logic [15:0] instr, input int hold,
                            input bit detail);
    int t = 0;
    while (!input_pc_ready && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) check("ready_timeout", 32'd1, 32'd0);
    input_pc = pc;
    input_pc_valid = 1'b1;
    step(hold);
    input_pc_valid = 1'b0;
    t = 0;
    while (!memory_valid && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) check("memvalid_timeout", 32'd1, 32'd0);
    if (detail) begin
      check("mem_valid_pre", {31'd0, memory_valid}, 32'd1);
      check("mem_addr", {21'd0, memory_addr}, {24'd0, pc});
      check("running_busy", {31'd0, running}, 32'd1);
    end
    memory_ready = 1'b1;
    step(1);
    memory_ready = 1'b0;
    memory_data = instr;
    if (detail) begin
      check("mem_valid_post", {31'd0, memory_valid}, 32'd0);
      check("running_m", {31'd0, running}, 32'd1);
    end
    step(1);
    memory_data = 16'hFFFF;
  endtask

  initial begin
    int a0;
    step(3);
    reset = 1'b0;
    step(30);
    check("rst_ready", {31'd0, input_pc_ready}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_memvalid", {31'd0, memory_valid}, 32'd0);
    check("rst_outvalid", {31'd0, output_pc_valid}, 32'd0);
    check("rst_accepts", {31'd0, accepts}, 32'd0);

    // Basic MATCH hit, PC held valid two cycles: exactly one output 0x06.
    current_character = 8'h61;
    exp_q.push_back({1'b0, 8'h06});
    run_thread(8'h05, {MATCH, 5'd0, 8'h61}, 2, 1'b1);
    wait_idle("idle_match");
    for (int i = 0; i < 3; i++) begin
      check("idle_after", {31'd0, running}, 32'd0);
      step(1);
    end

    // MATCH misses: thread dies with no output.
    for (int k = 1; k <= 31; k++) begin
      logic [7:0] op;
      op = 8'h61 + 8'(k);
      run_thread(8'h05, {MATCH, 5'd0, op}, 1, 1'b0);
      wait_idle("idle_miss");
    end
    step(2);
    check("miss_stays_idle", {31'd0, running}, 32'd0);

    // Sampled sweep of pc x character with MATCH / NOT_MATCH pairs.
    for (int p = 0; p <= 126; p += 9) begin
      for (int c = 0; c <= 253; c += 23) begin
        logic [7:0] pp, cc, cn;
        pp = 8'(p);
        cc = 8'(c);
        cn = 8'(c + 1);
        current_character = cc;
        exp_q.push_back({1'b0, pp + 8'd1});
        run_thread(pp, {MATCH, 5'd0, cc}, 1, 1'b0);
        wait_idle("idle_sweep");
        run_thread(pp, {MATCH, 5'd0, cn}, 1, 1'b0);
        wait_idle("idle_sweep");
        exp_q.push_back({1'b0, pp + 8'd1});
        run_thread(pp, {NOT_MATCH, 5'd0, cn}, 1, 1'b0);
        wait_idle("idle_sweep");
        run_thread(pp, {NOT_MATCH, 5'd0, cc}, 1, 1'b0);
        wait_idle("idle_sweep");
      end
    end

    // MATCH_ANY at the top PC wraps to 0; END produces nothing; JMP targets current char.
    exp_q.push_back({1'b0, 8'h00});
    run_thread(8'hFF, {MATCH_ANY, 13'h0000}, 1, 1'b0);
    wait_idle("idle_wrap");
    run_thread(8'h33, {ENDW, 13'h0012}, 1, 1'b0);
    wait_idle("idle_end");
    exp_q.push_back({1'b1, 8'h9A});
    run_thread(8'h30, {JMP, 13'h009A}, 1, 1'b0);
    wait_idle("idle_jmp");

    // SPLIT with consumer stalled for 4 cycles.
    output_pc_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h11});
    exp_q.push_back({1'b1, 8'h20});
    run_thread(8'h10, {SPLIT, 13'h0020}, 1, 1'b0);
    step(4);
    check("split_held_valid", {31'd0, output_pc_valid}, 32'd1);
    check("split_head_pc", {24'd0, output_pc}, 32'h11);
    check("split_head_dir", {31'd0, output_pc_is_directed_to_current}, 32'd1);
    output_pc_ready = 1'b1;
    wait_idle("idle_split");

    // Fill the FIFO with two SPLITs, then a JMP stalls in E until the consumer drains.
    output_pc_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h41});
    exp_q.push_back({1'b1, 8'h50});
    exp_q.push_back({1'b1, 8'h61});
    exp_q.push_back({1'b1, 8'h70});
    exp_q.push_back({1'b1, 8'h80});
    run_thread(8'h40, {SPLIT, 13'h0050}, 1, 1'b0);
    run_thread(8'h60, {SPLIT, 13'h0070}, 1, 1'b0);
    run_thread(8'h77, {JMP, 13'h0080}, 1, 1'b0);
    step(4);
    check("full_stall_running", {31'd0, running}, 32'd1);
    check("full_head_pc", {24'd0, output_pc}, 32'h41);
    output_pc_ready = 1'b1;
    wait_idle("idle_full");

    // ACCEPT / ACCEPT_PARTIAL pulses.
    current_character = 8'h00;
    a0 = acc_cnt;
    run_thread(8'h02, {ACCEPT, 13'h0000}, 1, 1'b0);
    wait_idle("idle_acc");
    step(2);
    check("accept_nul", acc_cnt - a0, 32'd1);
    current_character = 8'h78;
    a0 = acc_cnt;
    run_thread(8'h02, {ACCEPT, 13'h0000}, 1, 1'b0);
    wait_idle("idle_acc");
    step(2);
    check("accept_nonnul", acc_cnt - a0, 32'd0);
    a0 = acc_cnt;
    run_thread(8'h03, {ACCEPT_PARTIAL, 13'h0000}, 1, 1'b0);
    wait_idle("idle_accp");
    step(2);
    check("accept_partial", acc_cnt - a0, 32'd1);

    // Reset mid-fetch with an entry parked in the FIFO: everything discarded.
    output_pc_ready = 1'b0;
    run_thread(8'h44, {MATCH_ANY, 13'h0000}, 1, 1'b0);
    step(3);
    check("pre_rst_outvalid", {31'd0, output_pc_valid}, 32'd1);
    input_pc = 8'h55;
    input_pc_valid = 1'b1;
    step(1);
    input_pc_valid = 1'b0;
    check("pre_rst_memvalid", {31'd0, memory_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_memvalid", {31'd0, memory_valid}, 32'd0);
    check("mid_rst_outvalid", {31'd0, output_pc_valid}, 32'd0);
    check("mid_rst_running", {31'd0, running}, 32'd0);
    check("mid_rst_ready", {31'd0, input_pc_ready}, 32'd1);
    check("mid_rst_accepts", {31'd0, accepts}, 32'd0);
    step(2);
    reset = 1'b0;
    output_pc_ready = 1'b1;
    step(5);
    check("post_rst_outvalid", {31'd0, output_pc_valid}, 32'd0);
    check("post_rst_running", {31'd0, running}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regex_cpu_pipelined.md
Name: regex_cpu_pipelined

Overview:
Single-thread-per-slot regex virtual-machine core with a pipelined structure: fetch → memory wait → execute → output FIFO.
- Accepts a thread PC, fetches one instruction word from shared instruction memory through a request/ready handshake, and executes it against current_character.
- Emits the resulting successor PC(s) through a valid/ready output port, tagged as targeting the current or the next character.
- Sits between the engine's thread scheduler (PC source/sink) and the instruction memory arbiter.

Parameters:
PC_WIDTH, 8, width of thread program counters
CHARACTER_WIDTH, 8, width of input characters
MEMORY_WIDTH, 16, instruction word width
MEMORY_ADDR_WIDTH, 11, instruction memory address width
FIFO_WIDTH_POWER_OF_2, 2, log2 of output FIFO depth (default depth 4)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
current_character  in  CHARACTER_WIDTH  character being processed
input_pc_valid  in  1  input PC offered
input_pc  in  PC_WIDTH  PC to execute
input_pc_ready  out  1  core can take a PC this cycle
memory_ready  in  1  memory accepts the request this cycle
memory_addr  out  MEMORY_ADDR_WIDTH  instruction address (zero-extended PC)
memory_data  in  MEMORY_WIDTH  instruction word, valid one cycle after request acceptance
memory_valid  out  1  fetch request pending
output_pc_is_directed_to_current  out  1  1 = output PC runs on the current character; 0 = on the next character
output_pc_valid  out  1  output PC available (FIFO non-empty)
output_pc  out  PC_WIDTH  successor PC
output_pc_ready  in  1  consumer takes output PC
accepts  out  1  accepting instruction executed
running  out  1  any stage or the FIFO occupied

Behaviour:
Instruction word layout:
- opcode = bits [MEMORY_WIDTH-1:MEMORY_WIDTH-3]; data = remaining low bits.
- Character operand = data[CHARACTER_WIDTH-1:0]; jump target = data[PC_WIDTH-1:0].
- Opcodes: ACCEPT=0, SPLIT=1, MATCH=2, JMP=3, END_WITHOUT_ACCEPTING=4, MATCH_ANY=5, ACCEPT_PARTIAL=6, NOT_MATCH=7.

Reset (asynchronous): all stage valids cleared, FIFO emptied. Outputs after reset: memory_valid=0, output_pc_valid=0, accepts=0, running=0, input_pc_ready=1.

F stage (fetch):
- Registered; input_pc_ready = F stage empty. No bypass: ready never rises in the same cycle the F request is accepted by memory, so a held input_pc_valid is never double-accepted.
- input_pc_valid && input_pc_ready at an edge loads the PC; memory_valid=1 and memory_addr=PC from the next cycle.
- Request completes at the edge where memory_valid && memory_ready. The PC then moves to the M stage, F becomes empty, and memory_valid=0 from the following cycle.
- F may not hand off while M or E is occupied and cannot advance; it then holds the request with memory_valid deasserted.

M stage: captures memory_data at the edge one cycle after request acceptance, into E together with the PC.

E stage, executed against current_character:
- MATCH: operand == current_character → push pc+1, dir=0; else thread dies, nothing pushed.
- NOT_MATCH: operand != current_character → push pc+1, dir=0; else dies.
- MATCH_ANY: push pc+1, dir=0.
- JMP: push target, dir=1.
- SPLIT: push pc+1, dir=1, then target, dir=1, on two consecutive push cycles; E is held for the second push.
- ACCEPT: if current_character == 0, pulse accepts for one cycle; nothing pushed.
- ACCEPT_PARTIAL: pulse accepts unconditionally; nothing pushed.
- END_WITHOUT_ACCEPTING: nothing pushed.

Execute/push rules:
- A push happens only when the FIFO is not full; otherwise E stalls and back-pressures M and F.
- pc+1 wraps modulo 2^PC_WIDTH.

Output FIFO:
- Depth 2^FIFO_WIDTH_POWER_OF_2.
- output_pc_valid = non-empty; pop on valid && ready.
- Each pushed entry is presented exactly once.
- Simultaneous push and pop allowed when full.

running = F | M | E valid | FIFO non-empty (combinational). Drops in the cycle after the last pop, or after a dying thread leaves E.

Reset mid-operation discards every in-flight thread and the FIFO contents.

Test Plan:
- Reset, idle 30 cycles → input_pc_ready=1, running=0, memory_valid=0, output_pc_valid=0.
- input_pc=0x05 held valid 2 cycles, memory_ready pulsed once, memory_data={MATCH,'a'}, current_character='a':
  - memory_valid=1 with memory_addr=0x05 before the handshake, 0 after it; running=1.
  - Output 0x06 with dir=0, popped once, no repeat.
  - running=0 in each of the next 3 cycles.
- Same fetch with memory_data={MATCH,'a'+k}, k=1..31, current_character='a' → no output_pc_valid ever; running falls to 0 and stays 0.
- Sweep pc 0..126 × character 0..253 with the match/mismatch pairs above → pc+1 output only on equality.
- SPLIT target 0x20 at pc 0x10, output_pc_ready held low 4 cycles → FIFO holds 0x11 then 0x20, both dir=1, delivered in order.
- ACCEPT with current_character=0 → accepts pulses 1 cycle, no output. ACCEPT_PARTIAL with 'x' → accepts pulses. Reset asserted mid-fetch → all outputs return to reset values immediately.
